// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the fetch/decode front end: opcode constants,
// ALU / immediate-format / result-select encodings, the NOP used for
// bubbles, and the funct3 -> ALU operation map.
package fetch_decode_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // addi x0, x0, 0
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_e;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_J = 3'd3,
      IMM_U = 3'd4
   } imm_src_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   // sub_sel is only meaningful for register-register ops (funct7[5]).
   function automatic alu_ctrl_e alu_decode(input logic [2:0] funct3, input logic sub_sel);
      case (funct3)
         3'b000:  return sub_sel ? ALU_SUB : ALU_ADD;
         3'b010:  return ALU_SLT;
         3'b110:  return ALU_OR;
         3'b111:  return ALU_AND;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/fetch_decode_pipe_if.sv
// Instruction-memory bus between the fetch stage and the external,
// combinationally-read instruction memory.
//   imem_addr  : fetch address (current PC), driven by the fetch side
//   imem_rdata : instruction word at imem_addr, same cycle
// master = fetch stage, slave = instruction memory.
interface fetch_decode_pipe_if
   import fetch_decode_pkg::*;
#(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0] imem_rdata;

   modport master (output imem_addr, input imem_rdata);
   modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_decode_pipe_imm_gen.sv
// imm_gen: combinational immediate extender. Selects one of the five
// RV32I immediate layouts and sign-extends it from instr[31].
//   instr   : instruction bits [31:7] (opcode bits carry no immediate)
//   imm_src : immediate format select
//   imm     : sign-extended immediate, DATA_WIDTH bits
module imm_gen
   import fetch_decode_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [31:7]           instr,
   input  imm_src_e              imm_src,
   output logic [DATA_WIDTH-1:0] imm
);

   always_comb begin
      imm = '0;
      case (imm_src)
         IMM_I:   imm = DATA_WIDTH'($signed(instr[31:20]));
         IMM_S:   imm = DATA_WIDTH'($signed({instr[31:25], instr[11:7]}));
         IMM_B:   imm = DATA_WIDTH'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
         IMM_J:   imm = DATA_WIDTH'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
         IMM_U:   imm = DATA_WIDTH'($signed({instr[31:12], 12'b0}));
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/fetch_decode_pipe.sv
// fetch_decode_pipe: two-stage RISC-V front end (PC/fetch + IF/ID register
// with RV32I-subset decode).
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   stall, flush                 : hold / bubble control for PC and IF/ID
//   branch_taken, branch_target  : redirect from EX (wins over stall)
//   imem (master)                : instruction-memory address/data bus
//   id_valid, id_pc              : decode slot holds a real instruction, its PC
//   rs1, rs2, rd                 : register fields
//   ImmOp, ALUctrl, ALUsrc       : immediate, ALU operation, immediate-operand select
//   RegWrite, MemWrite, Branch, Jump, ResultSrc, illegal : control outputs
// Build option FETCH_PERF_EN adds fetch_count / bubble_count counters.
module fetch_decode_pipe
   import fetch_decode_pkg::*;
#(
   parameter int                    DATA_WIDTH    = 32,
   parameter int                    ADDRESS_WIDTH = 5,
   parameter logic [DATA_WIDTH-1:0] PC_RESET      = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic                     flush,
   input  logic                     branch_taken,
   input  logic [DATA_WIDTH-1:0]    branch_target,
   fetch_decode_pipe_if.master      imem,
   output logic                     id_valid,
   output logic [DATA_WIDTH-1:0]    id_pc,
   output logic [ADDRESS_WIDTH-1:0] rs1,
   output logic [ADDRESS_WIDTH-1:0] rs2,
   output logic [ADDRESS_WIDTH-1:0] rd,
   output logic [DATA_WIDTH-1:0]    ImmOp,
   output logic [2:0]               ALUctrl,
   output logic                     ALUsrc,
   output logic                     RegWrite,
   output logic                     MemWrite,
   output logic                     Branch,
   output logic                     Jump,
   output logic [1:0]               ResultSrc,
   output logic                     illegal
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]              fetch_count,
   output logic [31:0]              bubble_count
`endif
);

   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] id_instr_q, id_instr_d;
   logic [DATA_WIDTH-1:0] id_pc_q, id_pc_d;
   logic                  id_valid_q, id_valid_d;
   logic                  capture, bubble;

   // Redirect beats stall; stall+flush bubbles the slot but keeps the PC.
   always_comb begin
      pc_d       = pc_q + DATA_WIDTH'(4);
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
      id_valid_d = id_valid_q;
      capture    = 1'b0;
      bubble     = 1'b0;
      if (branch_taken) begin
         pc_d   = branch_target;
         bubble = 1'b1;
      end else if (stall) begin
         pc_d   = pc_q;
         bubble = flush;
      end else if (flush) begin
         bubble = 1'b1;
      end else begin
         capture = 1'b1;
      end
      if (bubble) begin
         id_instr_d = DATA_WIDTH'(NOP);
         id_pc_d    = '0;
         id_valid_d = 1'b0;
      end else if (capture) begin
         id_instr_d = imem.imem_rdata;
         id_pc_d    = pc_q;
         id_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= PC_RESET;
         id_instr_q <= DATA_WIDTH'(NOP);
         id_pc_q    <= '0;
         id_valid_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         id_instr_q <= id_instr_d;
         id_pc_q    <= id_pc_d;
         id_valid_q <= id_valid_d;
      end
   end

   assign imem.imem_addr = pc_q;
   assign id_valid       = id_valid_q;
   assign id_pc          = id_pc_q;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        dec_reg_write, dec_mem_write, dec_branch, dec_jump, dec_illegal;
   logic        dec_alu_src, dec_rs1_zero;
   alu_ctrl_e   dec_alu;
   imm_src_e    dec_imm_src;
   result_src_e dec_result;

   assign opcode = id_instr_q[6:0];
   assign funct3 = id_instr_q[14:12];

   always_comb begin
      dec_reg_write = 1'b0;
      dec_mem_write = 1'b0;
      dec_branch    = 1'b0;
      dec_jump      = 1'b0;
      dec_illegal   = 1'b0;
      dec_alu_src   = 1'b0;
      dec_rs1_zero  = 1'b0;
      dec_alu       = ALU_ADD;
      dec_imm_src   = IMM_I;
      dec_result    = RES_ALU;
      case (opcode)
         OP_R: begin
            dec_reg_write = 1'b1;
            dec_alu       = alu_decode(funct3, id_instr_q[30]);
         end
         OP_IALU: begin
            dec_reg_write = 1'b1;
            dec_alu_src   = 1'b1;
            dec_alu       = alu_decode(funct3, 1'b0);
         end
         OP_LOAD: begin
            dec_reg_write = 1'b1;
            dec_alu_src   = 1'b1;
            dec_result    = RES_MEM;
         end
         OP_STORE: begin
            dec_mem_write = 1'b1;
            dec_alu_src   = 1'b1;
            dec_imm_src   = IMM_S;
         end
         OP_BRANCH: begin
            dec_branch  = 1'b1;
            dec_alu     = ALU_SUB;
            dec_imm_src = IMM_B;
         end
         OP_JAL: begin
            dec_reg_write = 1'b1;
            dec_jump      = 1'b1;
            dec_result    = RES_PC4;
            dec_imm_src   = IMM_J;
         end
         OP_LUI: begin
            dec_reg_write = 1'b1;
            dec_alu_src   = 1'b1;
            dec_imm_src   = IMM_U;
            dec_rs1_zero  = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
      .instr   (id_instr_q[31:7]),
      .imm_src (dec_imm_src),
      .imm     (ImmOp)
   );

   // LUI reads x0 so the add in EX passes the upper immediate through.
   assign rs1       = dec_rs1_zero ? '0 : ADDRESS_WIDTH'(id_instr_q[19:15]);
   assign rs2       = ADDRESS_WIDTH'(id_instr_q[24:20]);
   assign rd        = ADDRESS_WIDTH'(id_instr_q[11:7]);
   assign ALUctrl   = dec_alu;
   assign ALUsrc    = dec_alu_src;
   assign ResultSrc = dec_result;
   assign RegWrite  = dec_reg_write & id_valid_q;
   assign MemWrite  = dec_mem_write & id_valid_q;
   assign Branch    = dec_branch & id_valid_q;
   assign Jump      = dec_jump & id_valid_q;
   assign illegal   = dec_illegal & id_valid_q;

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] bubble_count_q, bubble_count_d;

   always_comb begin
      fetch_count_d  = fetch_count_q + 32'(capture);
      bubble_count_d = bubble_count_q + 32'(bubble);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count_q  <= '0;
         bubble_count_q <= '0;
      end else begin
         fetch_count_q  <= fetch_count_d;
         bubble_count_q <= bubble_count_d;
      end
   end

   assign fetch_count  = fetch_count_q;
   assign bubble_count = bubble_count_q;
`endif

endmodule

// File: doc/fetch_decode_pipe.md
Name: fetch_decode_pipe

Overview:
- Parametrised two-stage front end for the RISC-V core: PC register, instruction-memory fetch, IF/ID pipeline register and full RV32I-subset decode.
- Handles stall, flush and branch/jump redirect.
- Feeds the execute stage with register addresses, a sign-extended immediate for all five immediate formats, and a multi-bit ALU control.
- Instruction memory is external, with a combinational read.

Parameters:
- DATA_WIDTH, 32, instruction/PC/immediate width
- ADDRESS_WIDTH, 5, register-file address width
- PC_RESET, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall  in  1  hold PC and IF/ID register
- flush  in  1  turn IF/ID contents into a bubble
- branch_taken  in  1  redirect fetch, resolved in EX
- branch_target  in  DATA_WIDTH  redirect address
- imem_addr  out  DATA_WIDTH  fetch address (= PC)
- imem_rdata  in  DATA_WIDTH  instruction at imem_addr, same cycle
- id_valid  out  1  decode outputs hold a real instruction
- id_pc  out  DATA_WIDTH  PC of decoded instruction
- rs1, rs2, rd  out  ADDRESS_WIDTH  register fields
- ImmOp  out  DATA_WIDTH  sign-extended immediate
- ALUctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ALUsrc  out  1  1 = immediate operand
- RegWrite, MemWrite, Branch, Jump  out  1  control strobes
- ResultSrc  out  2  00 ALU, 01 memory, 10 PC+4
- illegal  out  1  unsupported opcode in a valid slot

Behaviour:
- Reset: synchronous, active-high.
  - PC <= PC_RESET.
  - IF/ID register <= bubble: id_valid=0, instruction 32'h0000_0013, id_pc=0.
  - Outputs during and after reset: all strobes 0, illegal=0, ImmOp=0, ALUctrl=000.
- Priority each cycle: rst > branch_taken > stall > flush.
- PC update:
  - branch_taken: PC <= branch_target, regardless of stall.
  - Else if stall: PC holds.
  - Else: PC <= PC+4, modulo 2^DATA_WIDTH; wraps silently.
- IF/ID register:
  - branch_taken: bubble.
  - Else if stall: hold. If stall and flush are both high: bubble, PC holds.
  - Else if flush: bubble, PC still advances.
  - Else: capture {imem_rdata, PC}, id_valid=1.
- Latency: instruction fetched at PC=X appears on decode outputs in the cycle after imem_addr=X. Exactly one bubble follows every redirect.
- Decode: combinational from the IF/ID register.
  - When id_valid=0: RegWrite, MemWrite, Branch, Jump and illegal are forced to 0.
- Opcodes:
  - 0110011 R: RegWrite.
  - 0010011 I-ALU: RegWrite, ALUsrc, imm I.
  - 0000011 load: RegWrite, ALUsrc, ResultSrc=01, imm I, add.
  - 0100011 store: MemWrite, ALUsrc, imm S, add.
  - 1100011 branch: Branch, sub, imm B.
  - 1101111 JAL: RegWrite, Jump, ResultSrc=10, imm J.
  - 0110111 LUI: RegWrite, ALUsrc, imm U, add (rs1 forced to 0).
  - Anything else: illegal=1, all strobes 0.
- ALUctrl for R and I-ALU, from funct3:
  - 000: add, or sub if R and funct7[5]=1.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Other funct3: add.
- Immediate formats (all sign-extend from instr[31]):
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U = {instr[31:12], 12'b0}.
- rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7], truncated or zero-extended to ADDRESS_WIDTH.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs fetch_count and bubble_count (32 bits each).
  - Both reset to 0.
  - fetch_count increments on every IF/ID capture with id_valid=1.
  - bubble_count increments on every cycle a bubble is inserted.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package fetch_decode_pkg:
  - Opcode constants.
  - ALUctrl enum.
  - ImmSrc enum (I, S, B, J, U).
  - ResultSrc enum.
  - NOP constant 32'h0000_0013.
- One sub-module, imm_gen: a combinational ImmSrc-driven extender. Pipeline and decode stay in the top.

Test Plan:
- Reset with PC_RESET=32'h100, release, no stall -> imem_addr 100, 104, 108. id_pc=100 one cycle after release. id_valid low during reset.
- imem_rdata=32'hFFC00093 (addi x1,x0,-4) -> RegWrite=1, ALUsrc=1, rd=1, ImmOp=32'hFFFFFFFC, ALUctrl=000.
- stall high for 3 cycles while the PC=0x108 instruction is in ID -> imem_addr stays 0x10C and ID outputs are unchanged. Fetch resumes 0x10C, 0x110.
- branch_taken with branch_target=32'h200, stall also high -> next imem_addr=200. One bubble (id_valid=0, RegWrite=0), then id_pc=200.
- flush and stall together -> IF/ID becomes a bubble and PC holds. Opcode 1110011 in a valid slot -> illegal=1, all strobes 0.
- JAL 32'h0080006F -> Jump=1, ResultSrc=10, ImmOp=8. With FETCH_PERF_EN, 10 fetches plus 1 redirect -> fetch_count=10, bubble_count=1.
